grid_led_shift_tx: RTL and testbench
====================================

// Module: grid_led_shift_tx
// PURPOSE
//  Transmit side of the GPIO grid link. The game reads the 3x3 pad on gp_input; this block
//  drives the pad's LED layer, sending the 9-bit board pattern (bit 0 = top-left, row-major)
//  over a 3-wire shift-register interface (data, shift clock, latch) on GPIO outputs.
//  Sits beside datapath in finalproject; datapath pulses send when board changes.
// PARAMETERS
//  DATA_W    9  bits per frame, shifted MSB first.
//  HALF_DIV  2  CLOCK_50 cycles per half shift-clock period; must be >= 1.
// PORTS
//  CLOCK_50   in   1       sole clock; all logic on the rising edge.
//  reset      in   1       synchronous, active-high; aborts any frame.
//  board_in   in   DATA_W  frame payload, sampled only on the accept cycle.
//  send       in   1       request; accepted when send && ready at a clock edge.
//  ready      out  1       idle, can accept a request.
//  done       out  1       one-cycle pulse when the latch phase completes.
//  ser_data   out  1       serial data (GPIO); stable across each ser_clk rising edge.
//  ser_clk    out  1       shift clock (GPIO); external device samples on the rising edge.
//  ser_latch  out  1       storage latch (GPIO); high for HALF_DIV cycles after the last bit.
// BEHAVIOUR
//  Reset values: ready=1, done=0, ser_data=0, ser_clk=0, ser_latch=0, FSM=IDLE, counters=0.
//  FSM: IDLE -> SHIFT -> LATCH -> DONE -> IDLE.
//   IDLE:  ready=1. On send, capture board_in into shift_reg and go to SHIFT; ready=0 next cycle.
//   SHIFT: N=HALF_DIV, W=DATA_W; accept edge is cycle t.
//          Bit i (i=0..W-1, MSB first) drives ser_data during cycles t+1+2Ni .. t+2N(i+1).
//          ser_clk is 0 for the first N cycles of each bit window and 1 for the last N.
//   LATCH: after the last bit, ser_data=0, ser_clk=0, ser_latch=1 for cycles
//          t+2NW+1 .. t+2NW+N.
//   DONE:  at cycle t+2NW+N+1, done=1 and ready=1 (same cycle), then IDLE.
//          send is accepted again in this cycle.
//  Latency: accept to done = 2*N*W+N+1 cycles (39 for the defaults).
//  send while ready=0 is ignored; it is neither queued nor counted. board_in changes mid-frame
//   have no effect.
//  send held high continuously gives back-to-back frames; each frame takes a fresh board_in
//   on its accept (DONE) cycle.
//  Counters: div_cnt width $clog2(HALF_DIV)+1 and wraps at N-1. bit_cnt width $clog2(DATA_W)+1
//   and counts 0..W-1; no other wrap.
//  Reset mid-frame: all outputs return to reset values on the next edge, with no latch pulse,
//   so the external LEDs keep the previous frame. done is not asserted for an aborted frame.
//  Outputs are registered; none depend combinationally on inputs.
// STRUCTURE
//  grid_defs.vh: state localparams (S_IDLE, S_SHIFT, S_LATCH, S_DONE), default DATA_W=9,
//   board bit-order constants shared with datapath and the VGA path.
//  One sub-module, grid_bit_timer: div_cnt plus bit_cnt. It emits half_tick (end of each
//   half-period) and last_bit. The FSM and shift register stay in this module.
// TESTING
//  1 Reset, then send=1 for 1 cycle with board_in=9'b101010101 -> ready drops next cycle.
//    Rising-edge samples of ser_data read 1,0,1,0,1,0,1,0,1. One latch pulse of 2 cycles.
//    done=1 exactly 39 cycles after accept.
//  2 Frame in flight; pulse send with board_in=9'h1FF at bit 4 -> ignored. The frame completes
//    with the original data; no second frame follows.
//  3 send held high, board_in alternating 9'h0F0/9'h00F per accept -> consecutive frames
//    39 cycles apart, each carrying its own capture, and exactly one latch pulse per frame.
//  4 reset=1 for 1 cycle at bit 5 of a frame -> next cycle ser_*=0, ready=1. No latch pulse
//    and no done. The following send starts a clean frame with the full 9 bits.
//  5 HALF_DIV=1, DATA_W=4, board_in=4'b0011 -> ser_clk toggles every cycle, samples 0,0,1,1.
//    done at t+10.
//  6 Idle with send=0 for 100 cycles -> ser_clk, ser_latch and done stay 0, ready stays 1.

Source files
------------

// File: rtl/grid_led_shift_tx_pkg.sv
// Shared definitions for the grid LED shift-register transmitter.
package grid_led_shift_tx_pkg;
  localparam int DEF_DATA_W       = 9;
  localparam int DEF_HALF_DIV     = 2;
  // Board bit order, shared with datapath and the VGA path: bit 0 = top-left, row-major.
  localparam int BIT_TOP_LEFT     = 0;
  localparam int BIT_BOTTOM_RIGHT = DEF_DATA_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DONE} state_e;
endpackage

// File: rtl/grid_led_shift_tx_if.sv
// Request/handshake and GPIO serial lines of the LED transmitter.
interface grid_led_shift_tx_if
  import grid_led_shift_tx_pkg::*;
#(parameter int DATA_W = DEF_DATA_W);
  logic              send;
  logic [DATA_W-1:0] board_in;
  logic              ready;
  logic              done;
  logic              ser_data;
  logic              ser_clk;
  logic              ser_latch;

  modport master (output send, board_in,
                  input  ready, done, ser_data, ser_clk, ser_latch);
  modport slave  (input  send, board_in,
                  output ready, done, ser_data, ser_clk, ser_latch);
endinterface

// File: rtl/grid_led_shift_tx_bit_timer.sv
// Half-period divider and bit counter pacing the shift and latch phases.
module grid_led_shift_tx_bit_timer
  import grid_led_shift_tx_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int HALF_DIV = DEF_HALF_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic shift_en,
  input  logic latch_en,
  input  logic bit_adv,
  output logic half_tick,
  output logic last_bit
);
  localparam int DIV_W = $clog2(HALF_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(HALF_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    half_tick = (shift_en || latch_en) && (div_cnt_q == DIV_MAX);
    last_bit  = (bit_cnt_q == BIT_MAX);
    div_cnt_d = '0;
    if (shift_en || latch_en) div_cnt_d = half_tick ? '0 : div_cnt_q + 1'b1;
    // Bit index only lives while shifting, so every frame starts from bit 0.
    bit_cnt_d = '0;
    if (shift_en) bit_cnt_d = bit_adv ? bit_cnt_q + 1'b1 : bit_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end
endmodule

// File: rtl/grid_led_shift_tx.sv
// Sends the 9-bit board pattern MSB first to the LED shift register, then pulses the latch.
module grid_led_shift_tx
  import grid_led_shift_tx_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int HALF_DIV = DEF_HALF_DIV
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  grid_led_shift_tx_if.slave  bus
);
  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ser_clk_q, ser_clk_d;
  logic              ser_latch_q, ser_latch_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              half_tick, last_bit, bit_adv;

  grid_led_shift_tx_bit_timer #(.DATA_W(DATA_W), .HALF_DIV(HALF_DIV)) u_timer (
    .clk       (CLOCK_50),
    .rst       (reset),
    .shift_en  (state_q == S_SHIFT),
    .latch_en  (state_q == S_LATCH),
    .bit_adv   (bit_adv),
    .half_tick (half_tick),
    .last_bit  (last_bit)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    ser_clk_d   = ser_clk_q;
    ser_latch_d = ser_latch_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    bit_adv     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d     = S_IDLE;
        ready_d     = 1'b1;
        ser_clk_d   = 1'b0;
        ser_latch_d = 1'b0;
        if (bus.send) begin
          state_d = S_SHIFT;
          shift_d = bus.board_in;
          ready_d = 1'b0;
        end
      end
      S_SHIFT: if (half_tick) begin
        if (!ser_clk_q) begin
          ser_clk_d = 1'b1;
        end else begin
          // Shifting in zeros means ser_data falls to 0 once the last bit leaves.
          shift_d   = {shift_q[DATA_W-2:0], 1'b0};
          ser_clk_d = 1'b0;
          if (last_bit) begin
            state_d     = S_LATCH;
            ser_latch_d = 1'b1;
          end else begin
            bit_adv = 1'b1;
          end
        end
      end
      S_LATCH: if (half_tick) begin
        state_d     = S_DONE;
        ser_latch_d = 1'b0;
        done_d      = 1'b1;
        ready_d     = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      ser_clk_q   <= 1'b0;
      ser_latch_q <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      ser_clk_q   <= ser_clk_d;
      ser_latch_q <= ser_latch_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.ser_data  = shift_q[DATA_W-1];
  assign bus.ser_clk   = ser_clk_q;
  assign bus.ser_latch = ser_latch_q;
endmodule

// File: tb/tb_grid_led_shift_tx.sv
// Scoreboard bench: default instance plus a HALF_DIV=1, DATA_W=4 instance driven side by side.
module tb_grid_led_shift_tx;
  localparam int NA = 2, WA = 9, NB = 1, WB = 4;
  localparam int LAT_A = 2*NA*WA + NA + 1;
  localparam int LAT_B = 2*NB*WB + NB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  grid_led_shift_tx_if #(.DATA_W(WA)) bus_a ();
  grid_led_shift_tx_if #(.DATA_W(WB)) bus_b ();

  grid_led_shift_tx #(.DATA_W(WA), .HALF_DIV(NA)) dut_a (
    .CLOCK_50 (clk), .reset (rst), .bus (bus_a.slave));
  grid_led_shift_tx #(.DATA_W(WB), .HALF_DIV(NB)) dut_b (
    .CLOCK_50 (clk), .reset (rst), .bus (bus_b.slave));

  typedef struct { logic [8:0] bits; int done_cyc; } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  int cyc = 0, nvec = 0, nerr = 0;
  int last_acc[2]  = '{-1000, -1000};
  int abort_cyc[2] = '{-1, -1};
  int nacc[2]      = '{0, 0};
  int lat_of[2]    = '{LAT_A, LAT_B};
  int w_of[2]      = '{WA, WB};
  int n_of[2]      = '{NA, NB};
  bit started = 1'b0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, d, cyc, act, exp);
    end
  endtask

  // Reference model: a frame occupies LAT cycles; done shows in its last one.
  task automatic accept(input int d, input logic [8:0] data);
    exp_t e;
    e.bits     = data;
    e.done_cyc = cyc + lat_of[d] - 1;
    if (d == 0) qa.push_back(e); else qb.push_back(e);
    last_acc[d] = cyc;
    nacc[d]++;
  endtask

  task automatic step(input logic sa, input logic [8:0] da, input logic sb, input logic [3:0] db);
    bus_a.send = sa; bus_a.board_in = da;
    bus_b.send = sb; bus_b.board_in = db;
    @(posedge clk);
    cyc++;
    if (rst) begin
      qa.delete(); qb.delete();
      last_acc  = '{-1000, -1000};
      abort_cyc = '{cyc, cyc};
      started   = 1'b1;
    end else begin
      if (sa && cyc >= last_acc[0] + LAT_A) accept(0, da);
      if (sb && cyc >= last_acc[1] + LAT_B) accept(1, {5'b0, db});
    end
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 9'($urandom), 1'b0, 4'($urandom));
  endtask

  // Monitor: reconstructs each frame from the serial lines and checks it on done.
  int         nb[2], llen[2], lrise[2];
  logic [8:0] got[2];
  logic       pclk[2], pdat[2], plat[2];

  always @(negedge clk) if (started) begin
    for (int d = 0; d < 2; d++) begin
      logic c, dt, lt, dn, rd;
      int   qn;
      exp_t e;
      c  = (d == 0) ? bus_a.ser_clk   : bus_b.ser_clk;
      dt = (d == 0) ? bus_a.ser_data  : bus_b.ser_data;
      lt = (d == 0) ? bus_a.ser_latch : bus_b.ser_latch;
      dn = (d == 0) ? bus_a.done      : bus_b.done;
      rd = (d == 0) ? bus_a.ready     : bus_b.ready;
      qn = (d == 0) ? qa.size()       : qb.size();
      if (cyc == abort_cyc[d]) begin
        chk("reset_state", d, {27'b0, rd, dn, dt, c, lt}, 32'b10000);
        nb[d] = 0; got[d] = '0; llen[d] = 0; lrise[d] = 0;
      end else begin
        chk("ready", d, {31'b0, rd},
            (cyc >= last_acc[d] && cyc < last_acc[d] + lat_of[d] - 1) ? 32'd0 : 32'd1);
        if (c && !pclk[d]) begin
          chk("data_stable", d, {31'b0, dt}, {31'b0, pdat[d]});
          got[d] = {got[d][7:0], dt};
          nb[d]++;
        end
        if (lt) begin
          llen[d]++;
          if (!plat[d]) lrise[d]++;
          chk("latch_quiet", d, {30'b0, c, dt}, 32'd0);
        end
        if (qn == 0) begin
          chk("idle_lines", d, {29'b0, c, lt, dn}, 32'd0);
        end else if (dn) begin
          if (d == 0) e = qa.pop_front(); else e = qb.pop_front();
          chk("done_cycle",   d, cyc,       e.done_cyc);
          chk("frame_bits",   d, {23'b0, got[d]}, {23'b0, e.bits});
          chk("bit_count",    d, nb[d],     w_of[d]);
          chk("latch_len",    d, llen[d],   n_of[d]);
          chk("latch_pulses", d, lrise[d],  1);
          nb[d] = 0; got[d] = '0; llen[d] = 0; lrise[d] = 0;
        end
      end
      pclk[d] = c; pdat[d] = dt; plat[d] = lt;
    end
  end

  initial begin
    bus_a.send = 1'b0; bus_a.board_in = '0;
    bus_b.send = 1'b0; bus_b.board_in = '0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);

    // Alternating pattern on the default instance, 4'b0011 on the fast one.
    step(1'b1, 9'b101010101, 1'b1, 4'b0011);
    idle(45);

    // Request during bit 4 of a frame in flight must be dropped.
    step(1'b1, 9'h0A5, 1'b0, 4'h0);
    idle(2*NA*4);
    step(1'b1, 9'h1FF, 1'b1, 4'hF);
    idle(45);

    // send held high: back-to-back frames, each with its own capture.
    repeat (6*LAT_A) step(1'b1, (nacc[0] % 2 == 1) ? 9'h00F : 9'h0F0, 1'b0, 4'h0);
    idle(45);

    // Abort during bit 5, then a clean frame.
    step(1'b1, 9'h1C3, 1'b1, 4'hA);
    idle(2*NA*5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(5);
    step(1'b1, 9'h0B4, 1'b1, 4'h5);
    idle(45);

    // Random traffic with board_in changing every cycle.
    repeat (400) step($urandom_range(0, 7) == 0, 9'($urandom),
                      $urandom_range(0, 3) == 0, 4'($urandom));

    // Long idle stretch.
    idle(100);

    for (int k = 0; k < 100 && (qa.size() != 0 || qb.size() != 0); k++) idle(1);
    chk("drain", 0, qa.size() + qb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
